// File: rtl/rr_sched_pkg.sv
// Shared widths, request field offsets and command packing for the
// round-robin bank scheduler.
package rr_sched_pkg;

   // Request layout, LSB first: value, addr, we, valid.
   localparam int OFF_VALUE = 0;

   function automatic int off_addr(input int vw);
      return vw;
   endfunction

   function automatic int off_we(input int aw, input int vw);
      return aw + vw;
   endfunction

   function automatic int off_valid(input int aw, input int vw);
      return aw + vw + 1;
   endfunction

   function automatic int req_width(input int aw, input int vw);
      return aw + vw + 2;
   endfunction

   function automatic int bank_bits(input int nb);
      return (nb > 1) ? $clog2(nb) : 0;
   endfunction

   function automatic int local_addr_bits(input int aw, input int nb);
      return aw - bank_bits(nb);
   endfunction

   function automatic int plm_input_width(input int aw, input int vw, input int nb);
      return local_addr_bits(aw, nb) + vw + 1;
   endfunction

   function automatic int nkernels(input int nb, input int np);
      return nb * np;
   endfunction

   // Packs {we, local_addr, value}; caller narrows the result to its command width.
   function automatic logic [127:0] pack_cmd(input logic we, input logic [63:0] laddr,
                                             input logic [63:0] value, input int lab,
                                             input int vw);
      return ({127'b0, we} << (lab + vw)) | ({64'b0, laddr} << vw) | {64'b0, value};
   endfunction

endpackage

// File: rtl/rr_bank_arbiter.sv
// Rotating-priority arbiter for one bank: grants the first NPORTS matching
// consumers found scanning from the pointer, and computes the next pointer.
module rr_bank_arbiter #(
   parameter int NCONSUMERS = 2,
   parameter int NPORTS     = 1,
   localparam int PW        = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1
)(
   input  logic [NCONSUMERS-1:0]        i_match,
   input  logic [PW-1:0]                i_ptr,
   output logic [NPORTS*NCONSUMERS-1:0] o_sel,
   output logic [NCONSUMERS-1:0]        o_grant,
   output logic [PW-1:0]                o_ptr_nxt
);

   logic [NPORTS-1:0][NCONSUMERS-1:0] w_sel;
   logic [PW-1:0]                     w_idx;
   int                                w_cnt;
   int                                w_sum;
   int                                w_last;
   logic                              w_any;

   // Scan consumers in pointer order; the p-th match goes to port p.
   always_comb begin
      w_sel     = '0;
      o_grant   = '0;
      w_idx     = '0;
      w_cnt     = 0;
      w_sum     = 0;
      w_last    = 0;
      w_any     = 1'b0;
      o_ptr_nxt = i_ptr;
      for (int i = 0; i < NCONSUMERS; i++) begin
         w_sum = int'(i_ptr) + i;
         if (w_sum >= NCONSUMERS) w_sum = w_sum - NCONSUMERS;
         w_idx = PW'(w_sum);
         if (i_match[w_idx] && (w_cnt < NPORTS)) begin
            for (int p = 0; p < NPORTS; p++) begin
               if (p == w_cnt) w_sel[p][w_idx] = 1'b1;
            end
            o_grant[w_idx] = 1'b1;
            w_cnt          = w_cnt + 1;
            w_last         = w_sum;
            w_any          = 1'b1;
         end
      end
      w_sum = w_last + 1;
      if (w_sum >= NCONSUMERS) w_sum = 0;
      if (w_any) o_ptr_nxt = PW'(w_sum);
   end

   assign o_sel = w_sel;

endmodule

// File: rtl/rr_bank_scheduler.sv
// Round-robin scheduler from NCONSUMERS request sources onto NBANKS x NPORTS
// PLM bank ports. Grants are combinational; bank commands are registered.
// Optional build macro RR_PERF_CNT_EN adds a saturating conflict counter.
module rr_bank_scheduler
   import rr_sched_pkg::*;
#(
   parameter int  ADDR_WIDTH  = 4,
   parameter int  VALUE_WIDTH = 8,
   parameter int  NCONSUMERS  = 2,
   parameter int  NBANKS      = 1,
   parameter int  NPORTS      = 1,
   localparam int REQ_W       = req_width(ADDR_WIDTH, VALUE_WIDTH),
   localparam int PLM_W       = plm_input_width(ADDR_WIDTH, VALUE_WIDTH, NBANKS),
   localparam int NK          = nkernels(NBANKS, NPORTS)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NCONSUMERS*REQ_W-1:0] requests,
   output logic [NCONSUMERS-1:0]       grant,
   output logic [NK*PLM_W-1:0]         out,
   output logic [NK-1:0]               out_valid
`ifdef RR_PERF_CNT_EN
   ,
   output logic [31:0]                 conflict_cnt
`endif
);

   localparam int BB  = bank_bits(NBANKS);
   localparam int LAB = local_addr_bits(ADDR_WIDTH, NBANKS);
   localparam int BW  = (BB > 0) ? BB : 1;
   localparam int PW  = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

   logic [NCONSUMERS-1:0] w_valid;
   logic [NCONSUMERS-1:0] w_we;
   logic [ADDR_WIDTH-1:0] w_addr [NCONSUMERS];
   logic [BW-1:0]         w_bank [NCONSUMERS];
   logic [PLM_W-1:0]      w_cmd  [NCONSUMERS];
   logic [NCONSUMERS-1:0] w_bgrant [NBANKS];
   logic [NCONSUMERS-1:0] w_grant_any;

   for (genvar c = 0; c < NCONSUMERS; c++) begin : g_cons
      localparam int BASE = c * REQ_W;
      logic [VALUE_WIDTH-1:0] w_value;
      logic [LAB-1:0]         w_laddr;
      assign w_valid[c] = requests[BASE + off_valid(ADDR_WIDTH, VALUE_WIDTH)];
      assign w_we[c]    = requests[BASE + off_we(ADDR_WIDTH, VALUE_WIDTH)];
      assign w_addr[c]  = requests[BASE + off_addr(VALUE_WIDTH) +: ADDR_WIDTH];
      assign w_value    = requests[BASE + OFF_VALUE +: VALUE_WIDTH];
      if (BB == 0) begin : g_one_bank
         assign w_bank[c] = '0;
         assign w_laddr   = w_addr[c];
      end else begin : g_interleave
         assign w_bank[c] = w_addr[c][BB-1:0];
         assign w_laddr   = w_addr[c][ADDR_WIDTH-1:BB];
      end
      assign w_cmd[c] = PLM_W'(pack_cmd(w_we[c], 64'(w_laddr), 64'(w_value), LAB, VALUE_WIDTH));
   end

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic [NCONSUMERS-1:0]        w_match;
      logic [NPORTS*NCONSUMERS-1:0] w_sel;
      logic [PW-1:0]                w_ptr_nxt;
      logic [PW-1:0]                r_ptr;

      for (genvar c = 0; c < NCONSUMERS; c++) begin : g_match
         assign w_match[c] = w_valid[c] && (w_bank[c] == BW'(b));
      end

      rr_bank_arbiter #(
         .NCONSUMERS (NCONSUMERS),
         .NPORTS     (NPORTS)
      ) u_arb (
         .i_match   (w_match),
         .i_ptr     (r_ptr),
         .o_sel     (w_sel),
         .o_grant   (w_bgrant[b]),
         .o_ptr_nxt (w_ptr_nxt)
      );

      // Rotating-priority pointer for this bank.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) r_ptr <= '0;
         else        r_ptr <= w_ptr_nxt;
      end

      for (genvar p = 0; p < NPORTS; p++) begin : g_port
         localparam int K = b * NPORTS + p;
         logic [NCONSUMERS-1:0] w_s;
         logic [PLM_W-1:0]      w_mux;
         logic [PLM_W-1:0]      r_out;
         logic                  r_vld;

         assign w_s = w_sel[p*NCONSUMERS +: NCONSUMERS];

         // One-hot select of the granted consumer's packed command.
         always_comb begin
            w_mux = '0;
            for (int c = 0; c < NCONSUMERS; c++) begin
               if (w_s[c]) w_mux = w_mux | w_cmd[c];
            end
         end

         // Kernel command register; data holds when the port is idle.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_out <= '0;
               r_vld <= 1'b0;
            end else begin
               r_vld <= |w_s;
               if (|w_s) r_out <= w_mux;
            end
         end

         assign out[K*PLM_W +: PLM_W] = r_out;
         assign out_valid[K]          = r_vld;
      end
   end

   // A consumer targets a single bank, so OR-ing bank grants never collides.
   always_comb begin
      w_grant_any = '0;
      for (int b = 0; b < NBANKS; b++) w_grant_any = w_grant_any | w_bgrant[b];
   end

   assign grant = reset ? w_grant_any : '0;

`ifdef RR_PERF_CNT_EN
   logic [32:0] w_miss;
   logic [32:0] w_sum;
   logic [31:0] r_conflict;

   // Count valid requests that lost arbitration this cycle.
   always_comb begin
      w_miss = '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
         if (w_valid[c] && !w_grant_any[c]) w_miss = w_miss + 33'd1;
      end
      w_sum = {1'b0, r_conflict} + w_miss;
   end

   // Saturating conflict accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        r_conflict <= '0;
      else if (w_sum[32]) r_conflict <= '1;
      else               r_conflict <= w_sum[31:0];
   end

   assign conflict_cnt = r_conflict;
`endif

endmodule

// File: tb/tb_rr_bank_scheduler.sv
module tb_rr_bank_scheduler;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;

   // dut0: defaults (AW4 VW8 NC2 NB1 NP1)
   logic [27:0] req0;
   logic [1:0]  grant0;
   logic [12:0] out0;
   logic [0:0]  vld0;
`ifdef RR_PERF_CNT_EN
   logic [31:0] cnt0;
`endif
   // dut1: NB2 NC2 NP1
   logic [27:0] req1;
   logic [1:0]  grant1;
   logic [23:0] out1;
   logic [1:0]  vld1;
`ifdef RR_PERF_CNT_EN
   logic [31:0] cnt1;
`endif
   // dut2: NB1 NC3 NP2
   logic [41:0] req2;
   logic [2:0]  grant2;
   logic [25:0] out2;
   logic [1:0]  vld2;
`ifdef RR_PERF_CNT_EN
   logic [31:0] cnt2;
`endif

   rr_bank_scheduler u_dut0 (
      .clk(clk), .reset(reset), .requests(req0), .grant(grant0),
      .out(out0), .out_valid(vld0)
`ifdef RR_PERF_CNT_EN
      , .conflict_cnt(cnt0)
`endif
   );

   rr_bank_scheduler #(.NBANKS(2)) u_dut1 (
      .clk(clk), .reset(reset), .requests(req1), .grant(grant1),
      .out(out1), .out_valid(vld1)
`ifdef RR_PERF_CNT_EN
      , .conflict_cnt(cnt1)
`endif
   );

   rr_bank_scheduler #(.NCONSUMERS(3), .NPORTS(2)) u_dut2 (
      .clk(clk), .reset(reset), .requests(req2), .grant(grant2),
      .out(out2), .out_valid(vld2)
`ifdef RR_PERF_CNT_EN
      , .conflict_cnt(cnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] mk(input logic v, input logic we,
                                      input logic [3:0] a, input logic [7:0] d);
      return {v, we, a, d};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      req0  = '0;
      req1  = '0;
      req2  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      req0  = {mk(1, 1, 4'd3, 8'h55), mk(1, 1, 4'd3, 8'hAA)};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (grant0 !== 2'b00) begin
            errors++; $display("FAIL reset_grant cyc%0d got %b exp 00", i, grant0);
         end
         checks++;
         if (vld0 !== 1'b0) begin
            errors++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, vld0);
         end
         checks++;
         if (out0 !== 13'h0) begin
            errors++; $display("FAIL reset_out cyc%0d got %h exp 0", i, out0);
         end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (grant0 !== 2'b01) begin
         errors++; $display("FAIL reset_first_grant got %b exp 01", grant0);
      end
      @(posedge clk); #1;
      checks++;
      if (vld0 !== 1'b1 || out0 !== 13'h13AA) begin
         errors++; $display("FAIL reset_first_out got v=%b %h exp v=1 13aa", vld0, out0);
      end
   endtask

   task automatic test_rotation();
      logic [1:0]  eg;
      logic [12:0] eo;
      apply_reset();
      req0 = {mk(1, 1, 4'd3, 8'h55), mk(1, 1, 4'd3, 8'hAA)};
      for (int i = 0; i < 4; i++) begin
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
         eo = (i % 2 == 0) ? 13'h13AA : 13'h1355;
         #1;
         checks++;
         if (grant0 !== eg) begin
            errors++; $display("FAIL rot_grant cyc%0d got %b exp %b", i, grant0, eg);
         end
         @(posedge clk); #1;
         checks++;
         if (vld0 !== 1'b1 || out0 !== eo) begin
            errors++; $display("FAIL rot_out cyc%0d got v=%b %h exp v=1 %h", i, vld0, out0, eo);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_ptr_hold();
      apply_reset();
      req0 = {mk(1, 1, 4'd3, 8'h55), mk(0, 0, 4'd0, 8'h00)};
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (grant0 !== 2'b10) begin
            errors++; $display("FAIL hold_grant cyc%0d got %b exp 10", i, grant0);
         end
         @(posedge clk); #1;
         checks++;
         if (vld0 !== 1'b1 || out0 !== 13'h1355) begin
            errors++; $display("FAIL hold_out cyc%0d got v=%b %h exp v=1 1355", i, vld0, out0);
         end
         @(negedge clk);
      end
      req0 = {mk(1, 1, 4'd3, 8'h55), mk(1, 1, 4'd3, 8'hAA)};
      #1;
      checks++;
      if (grant0 !== 2'b01) begin
         errors++; $display("FAIL hold_dual_grant got %b exp 01", grant0);
      end
      @(posedge clk); #1;
      checks++;
      if (out0 !== 13'h13AA) begin
         errors++; $display("FAIL hold_dual_out got %h exp 13aa", out0);
      end
   endtask

   task automatic test_bank_parallel();
      apply_reset();
      req1 = {mk(1, 1, 4'd5, 8'h22), mk(1, 1, 4'd4, 8'h11)};
      #1;
      checks++;
      if (grant1 !== 2'b11) begin
         errors++; $display("FAIL banks_grant got %b exp 11", grant1);
      end
      @(posedge clk); #1;
      checks++;
      if (vld1 !== 2'b11) begin
         errors++; $display("FAIL banks_valid got %b exp 11", vld1);
      end
      checks++;
      if (out1[11:0] !== 12'hA11) begin
         errors++; $display("FAIL banks_out0 got %h exp a11", out1[11:0]);
      end
      checks++;
      if (out1[23:12] !== 12'hA22) begin
         errors++; $display("FAIL banks_out1 got %h exp a22", out1[23:12]);
      end
   endtask

   task automatic test_multi_port();
      logic [2:0]  eg [3];
      logic [12:0] ek0 [3];
      logic [12:0] ek1 [3];
      eg[0] = 3'b011; ek0[0] = 13'h0110; ek1[0] = 13'h0220;
      eg[1] = 3'b101; ek0[1] = 13'h0330; ek1[1] = 13'h0110;
      eg[2] = 3'b110; ek0[2] = 13'h0220; ek1[2] = 13'h0330;
      apply_reset();
      req2 = {mk(1, 0, 4'd3, 8'h30), mk(1, 0, 4'd2, 8'h20), mk(1, 0, 4'd1, 8'h10)};
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (grant2 !== eg[i]) begin
            errors++; $display("FAIL mp_grant cyc%0d got %b exp %b", i, grant2, eg[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (vld2 !== 2'b11 || out2[12:0] !== ek0[i] || out2[25:13] !== ek1[i]) begin
            errors++;
            $display("FAIL mp_out cyc%0d got v=%b %h %h exp v=11 %h %h",
                     i, vld2, out2[12:0], out2[25:13], ek0[i], ek1[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_midstream_reset();
      apply_reset();
      req0 = {mk(1, 1, 4'd3, 8'h55), mk(1, 1, 4'd3, 8'hAA)};
      repeat (5) @(posedge clk);
      #1;
`ifdef RR_PERF_CNT_EN
      checks++;
      if (cnt0 !== 32'd5) begin
         errors++; $display("FAIL cnt_accum got %0d exp 5", cnt0);
      end
`endif
      checks++;
      if (vld0 !== 1'b1 || out0 !== 13'h13AA) begin
         errors++; $display("FAIL mid_pre_out got v=%b %h exp v=1 13aa", vld0, out0);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (vld0 !== 1'b0 || out0 !== 13'h0 || grant0 !== 2'b00) begin
         errors++; $display("FAIL mid_reset got v=%b out=%h g=%b exp 0 0 00", vld0, out0, grant0);
      end
`ifdef RR_PERF_CNT_EN
      checks++;
      if (cnt0 !== 32'd0) begin
         errors++; $display("FAIL cnt_reset got %0d exp 0", cnt0);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (grant0 !== 2'b01) begin
         errors++; $display("FAIL mid_ptr_grant got %b exp 01", grant0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      req0   = '0;
      req1   = '0;
      req2   = '0;
      test_reset();
      test_rotation();
      test_ptr_hold();
      test_bank_parallel();
      test_multi_port();
      test_midstream_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
